// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the RAM arbiter slice.
// Owner encoding, default RAM depth and byte-enable masks.
package arm_mem_pkg;

  localparam int RAM_SIZE_DEF = 4096;

  localparam logic [3:0] BE_WORD = 4'hF;
  localparam logic [3:0] BE_B0   = 4'h1;
  localparam logic [3:0] BE_B1   = 4'h2;
  localparam logic [3:0] BE_B2   = 4'h4;
  localparam logic [3:0] BE_B3   = 4'h8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_addr_check.sv
// Combinational request checker: word alignment and RAM range.
// Ports: addr_i byte address; misalign_o, range_o, bad_o flags.
module mem_addr_check
  import arm_mem_pkg::*;
#(
  parameter int RAM_SIZE = RAM_SIZE_DEF
) (
  input  logic [31:0] addr_i,
  output logic        misalign_o,
  output logic        range_o,
  output logic        bad_o
);

  logic [31:0] word;

  assign word       = {2'b00, addr_i[31:2]};
  assign misalign_o = (addr_i[1:0] != 2'b00);
  assign range_o    = (word >= 32'(RAM_SIZE));
  assign bad_o      = misalign_o | range_o;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch, data) for a single-port sync RAM.
// Ports: if_* fetch side, d_* data side, ram_* RAM side, clk/reset.
module mem_arbiter
  import arm_mem_pkg::*;
#(
  parameter int RAM_SIZE     = RAM_SIZE_DEF,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        if_req,
  input  logic [31:0]                 if_addr,
  output logic                        if_gnt,
  output logic                        if_rvalid,
  output logic [31:0]                 if_rdata,
  output logic                        if_err,
  input  logic                        d_req,
  input  logic                        d_we,
  input  logic [3:0]                  d_be,
  input  logic [31:0]                 d_addr,
  input  logic [31:0]                 d_wdata,
  output logic                        d_gnt,
  output logic                        d_rvalid,
  output logic [31:0]                 d_rdata,
  output logic                        d_err,
  output logic                        ram_en,
  output logic [3:0]                  ram_we,
  output logic [$clog2(RAM_SIZE)-1:0] ram_addr,
  output logic [31:0]                 ram_wdata,
  input  logic [31:0]                 ram_rdata
);

  localparam int AW = $clog2(RAM_SIZE);
  localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);

  logic          if_mis, if_rng, if_bad;
  logic          d_mis, d_rng, d_bad;
  logic          gnt_d, gnt_if;
  logic [3:0]    run_q, run_d;
  owner_e        own_q, own_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          en_c;
  logic [3:0]    we_c;

  mem_addr_check #(.RAM_SIZE(RAM_SIZE)) u_if_chk (
    .addr_i     (if_addr),
    .misalign_o (if_mis),
    .range_o    (if_rng),
    .bad_o      (if_bad)
  );

  mem_addr_check #(.RAM_SIZE(RAM_SIZE)) u_d_chk (
    .addr_i     (d_addr),
    .misalign_o (d_mis),
    .range_o    (d_rng),
    .bad_o      (d_bad)
  );

  // Data wins unless fetch has waited out a full data run.
  // Grants are masked in reset so every output idles at 0.
  assign gnt_d  = !reset && d_req &&
                  (!if_req || (run_q != RUN_MAX));
  assign gnt_if = !reset && if_req && !gnt_d;

  always_comb begin
    run_d = run_q;
    if (!if_req || gnt_if) begin
      run_d = 4'd0;
    end else if (gnt_d && (run_q != RUN_MAX)) begin
      run_d = run_q + 4'd1;
    end
  end

  always_comb begin
    own_d   = OWN_NONE;
    we_d    = 1'b0;
    err_d   = 1'b0;
    en_c    = 1'b0;
    we_c    = 4'b0000;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (gnt_d) begin
      own_d = OWN_D;
      we_d  = d_we;
      err_d = d_bad;
      if (!d_bad) begin
        en_c    = 1'b1;
        we_c    = d_we ? d_be : 4'b0000;
        addr_d  = d_addr[AW+1:2];
        wdata_d = d_wdata;
      end
    end else if (gnt_if) begin
      own_d = OWN_IF;
      err_d = if_bad;
      if (!if_bad) begin
        en_c   = 1'b1;
        addr_d = if_addr[AW+1:2];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      own_q   <= OWN_NONE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      run_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      own_q   <= own_d;
      we_q    <= we_d;
      err_q   <= err_d;
      run_q   <= run_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign if_gnt    = gnt_if;
  assign d_gnt     = gnt_d;
  assign ram_en    = en_c;
  assign ram_we    = we_c;
  // Address/data pass straight through on an access, else hold.
  assign ram_addr  = addr_d;
  assign ram_wdata = wdata_d;

  assign if_rvalid = (own_q == OWN_IF);
  assign if_err    = if_rvalid && err_q;
  assign if_rdata  = (if_rvalid && !err_q) ? ram_rdata : 32'd0;

  assign d_rvalid  = (own_q == OWN_D);
  assign d_err     = d_rvalid && err_q;
  assign d_rdata   = (d_rvalid && !err_q && !we_q) ?
                     ram_rdata : 32'd0;

  logic unused;
  assign unused = ^{if_mis, if_rng, d_mis, d_rng};

endmodule
